fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side drain engine for the 36-bit, 512-deep block-RAM FIFO. Issues `fifo_rd_en` against the FIFO's `empty` flag, absorbs the FIFO's fixed read latency, and presents words on a valid/ready stream to downstream path-tracer logic. Sits entirely in the FIFO's read clock domain, so backpressure never loses a word already requested from the RAM.

## Interface
Parameters:
- `DATA_W`, 36: FIFO word width.
- `RD_LAT`, 2: cycles from `fifo_rd_en` high to `fifo_rd_data` valid. Legal range 1..3.
- `BUF_DEPTH`, `RD_LAT+2`: local buffer entries. Must be ≥ `RD_LAT+2`.

Ports:
- `rd_clk` in 1: the FIFO read clock. All logic is single-clock on this edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: drain enable.
- `fifo_empty` in 1: FIFO empty flag, in the `rd_clk` domain.
- `fifo_rd_en` out 1: FIFO read strobe.
- `fifo_rd_data` in `DATA_W`: FIFO read data.
- `m_valid` out 1: stream word valid.
- `m_ready` in 1: downstream accept.
- `m_data` out `DATA_W`: stream word.
- `idle` out 1: high when state is IDLE.
- `words_out` out 32: accepted-word count. Present only with `FIFO_RD_STATS_EN`.
- `stall_cycles` out 32: backpressure cycle count. Present only with `FIFO_RD_STATS_EN`.

## Operation
- **In-flight tracking:** `inflight` is an `RD_LAT`-bit shift register. Bit 0 is set by `fifo_rd_en`. When a bit exits, `fifo_rd_data` is pushed into the buffer in that cycle.
- **Buffer:** circular, `BUF_DEPTH` entries with head/tail pointers. Pointers wrap by explicit compare to `BUF_DEPTH-1` because the depth is not a power of two. `count` width is `$clog2(BUF_DEPTH+1)`.
- **Output:** `m_data` equals the head entry. `m_valid` equals `count != 0`.
- **Pop:** occurs on `m_valid && m_ready`. Push and pop may happen in the same cycle, and then `count` is unchanged.
- **Read issue rule:** `fifo_rd_en` = state==RUN && !`fifo_empty` && (`count` + popcount(`inflight`)) < `BUF_DEPTH`.
  - The buffer never overflows.
  - With `BUF_DEPTH = RD_LAT+2` and `m_ready` held high, throughput is one word per cycle.
- **FSM:**
  - IDLE → RUN when `enable`=1.
  - RUN → DRAIN when `enable`=0. In DRAIN no reads are issued; in-flight words land and buffered words are delivered.
  - DRAIN → IDLE when `inflight`==0 and `count`==0.
  - DRAIN → RUN when `enable`=1.
- **Boundaries:**
  - FIFO empty: no `fifo_rd_en`. The FIFO's `empty` flag updates the cycle after the last read, so back-to-back reads to the final word are safe.
  - Buffer full: reads stall and `m_valid` stays high.
  - `m_ready` low indefinitely: nothing is dropped and `m_data` is held stable.
  - `enable` toggling mid-stream: no word is duplicated or lost.

## Timing
- **Reset values:**
  - `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `idle`=1.
  - Counters = 0; state IDLE; `inflight`, `count` and pointers = 0.
- **Reset mid-operation:** in-flight and buffered words are discarded. The system resets the FIFO pointers at the same time.
- **Latency:**
  - `fifo_rd_en` high in cycle t → `fifo_rd_data` sampled at the end of cycle t+`RD_LAT`-1's successor, i.e. in cycle t+`RD_LAT`.
  - `m_valid` is high from cycle t+`RD_LAT`+1, so latency from strobe to stream is `RD_LAT`+1 cycles.
- **Enable to first read:** `enable` rising in cycle c with a non-empty FIFO → first `fifo_rd_en` in cycle c+1, since the state register is RUN from c+1.
- **Stream rules:** `m_valid` may not drop without a handshake, and `m_data` changes only after a pop.

## Configuration
- `FIFO_RD_STATS_EN` defined:
  - `words_out` increments on every handshake.
  - `stall_cycles` increments on every cycle with `m_valid` && !`m_ready`.
  - Both wrap modulo 2^32 and reset to 0.
- `FIFO_RD_STATS_EN` undefined: both ports and both counters are absent. Datapath behaviour is identical.

## Structure
- **Shared package `fifo_pkg`:** `FIFO_DATA_W`=36, `FIFO_DEPTH`=512, `FIFO_RD_LAT`=2, and the state enum `fifo_rd_state_t` {IDLE, RUN, DRAIN}.
- **Sub-module `fifo_rd_buf`:** the circular buffer, with push/pop, head data, `count` and the wrap logic. The top level holds the FSM, the issue rule, `inflight` and the stats.

## Test plan
- **Full throughput:** `RD_LAT`=2, FIFO preloaded with 0..99, `enable`=1, `m_ready`=1 → 100 words in order, one per cycle after a 3-cycle fill, with no gaps.
- **Backpressure:** `m_ready` low for 20 cycles mid-stream.
  - At most `BUF_DEPTH`=4 words are held, and `fifo_rd_en` stays low once full.
  - After release, the stream resumes with no loss or duplication.
  - With the stats macro, `stall_cycles` equals 20.
- **Empty FIFO:** single word 0x9_ABCD_1234 written into an empty FIFO → exactly one `fifo_rd_en` pulse, then `m_valid` for one handshake, then `m_valid`=0.
- **Drain:** `enable` dropped while 2 words are in flight and 1 is buffered → no further reads, 3 words delivered, `idle` rises after the last handshake.
- **Reset mid-stream:** `rst_n` asserted with the buffer at `count`=3 → all outputs return to reset values immediately (asynchronously). After release, `m_valid` stays 0 until a new read is issued.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and read-side state encoding for the block-RAM FIFO.
package fifo_pkg;
  localparam int FIFO_DATA_W = 36;
  localparam int FIFO_DEPTH  = 512;
  localparam int FIFO_RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fifo_rd_state_t;
endpackage

// File: rtl/fifo_rd_buf.sv
// Circular landing buffer for FIFO read data; depth need not be a power of two.
module fifo_rd_buf #(
  parameter int DATA_W = 36,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              rd_clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CNT_W-1:0]  count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  // Storage is reset so the stream word reads as zero out of reset.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= push_data_i;
        tail_q        <= (tail_q == LAST) ? '0 : tail_q + PTR_W'(1);
      end
      if (pop_i) head_q <= (head_q == LAST) ? '0 : head_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data_o = mem_q[head_q];
  assign count_o     = count_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read-side drain engine: issues reads, absorbs RAM latency, streams valid/ready.
// Optional counters words_out/stall_cycles are built when FIFO_RD_STATS_EN is defined.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int RD_LAT    = FIFO_RD_LAT,
  parameter int BUF_DEPTH = RD_LAT + 2
) (
  input  logic              rd_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              idle
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]       words_out,
  output logic [31:0]       stall_cycles
`endif
);
  // state | meaning
  // IDLE  | no reads, nothing in flight or buffered
  // RUN   | issuing reads while the buffer has room
  // DRAIN | no new reads; in-flight and buffered words still delivered
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W = CNT_W + 2;

  fifo_rd_state_t    state_q;
  logic              idle_q;
  logic [RD_LAT-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0]  count;
  logic [OCC_W-1:0]  occ;
  logic              push, pop;

  // Reserve buffer space for every word already requested from the RAM.
  always_comb begin
    occ = OCC_W'(count);
    for (int i = 0; i < RD_LAT; i++) occ = occ + OCC_W'(inflight_q[i]);
  end

  assign fifo_rd_en = (state_q == RUN) && !fifo_empty && (occ < OCC_W'(BUF_DEPTH));
  assign push       = inflight_q[RD_LAT-1];
  assign m_valid    = (count != '0);
  assign pop        = m_valid && m_ready;
  assign idle       = idle_q;

  always_comb begin
    inflight_d    = '0;
    inflight_d[0] = fifo_rd_en;
    for (int i = 1; i < RD_LAT; i++) inflight_d[i] = inflight_q[i-1];
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= '0;
    else        inflight_q <= inflight_d;
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idle_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (enable) begin
          state_q <= RUN;
          idle_q  <= 1'b0;
        end
        RUN: if (!enable) state_q <= DRAIN;
        DRAIN: begin
          if (enable) begin
            state_q <= RUN;
          end else if (inflight_q == '0 && count == '0) begin
            state_q <= IDLE;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  fifo_rd_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH),
    .CNT_W  (CNT_W)
  ) u_buf (
    .rd_clk      (rd_clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (fifo_rd_data),
    .pop_i       (pop),
    .head_data_o (m_data),
    .count_o     (count)
  );

`ifdef FIFO_RD_STATS_EN
  logic [31:0] words_q, stalls_q;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (pop)                 words_q  <= words_q + 32'd1;
      if (m_valid && !m_ready) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign words_out    = words_q;
  assign stall_cycles = stalls_q;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a latency-accurate FIFO model and scoreboard.
module tb_fifo_stream_reader;
  localparam int DW      = 36;
  localparam int LAT     = 2;
  localparam int BDEPTH  = LAT + 2;

  logic          rd_clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          idle;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]   words_out;
  logic [31:0]   stall_cycles;
`endif

  fifo_stream_reader #(.DATA_W(DW), .RD_LAT(LAT), .BUF_DEPTH(BDEPTH)) dut (
    .rd_clk       (rd_clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .idle         (idle)
`ifdef FIFO_RD_STATS_EN
    ,
    .words_out    (words_out),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_total = 0;
  int hs_total = 0;
  int max_occ = 0;
  int last_hs_cyc = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] stage1, stage2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  always @(posedge rd_clk) cyc++;

  // FIFO model: RD_LAT-cycle read pipeline; empty flag follows the pop at the edge.
  assign fifo_rd_data = stage2;
  always @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1     <= '0;
      stage2     <= '0;
      fifo_empty = 1'b1;
    end else begin
      stage2 <= stage1;
      if (fifo_rd_en) begin
        rd_total++;
        if (fq.size() == 0) begin
          check("rd_on_empty", 64'd1, 64'd0);
          stage1 <= '0;
        end else begin
          stage1 <= fq.pop_front();
        end
        if (rd_total - hs_total > max_occ) max_occ = rd_total - hs_total;
      end else begin
        stage1 <= '0;
      end
      fifo_empty = (fq.size() == 0);
    end
  end

  logic          prev_v, prev_r;
  logic [DW-1:0] prev_d;
  always @(negedge rd_clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_data", 64'(m_data), 64'(prev_d));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", 64'(m_data), 64'hDEAD);
        else check("stream_data", 64'(m_data), 64'(exp_q.pop_front()));
        hs_total++;
        last_hs_cyc = cyc;
      end
      prev_v = m_valid;
      prev_r = m_ready;
      prev_d = m_data;
    end
  end

  initial begin
    int base, rd_base, first_valid, start_cyc;
`ifdef FIFO_RD_STATS_EN
    int stall_base;
`endif
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge rd_clk);
    rst_n = 1'b1;
    @(negedge rd_clk);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);

    // Full throughput: 100 words, one per cycle after the fill.
    for (int i = 0; i < 100; i++) push_word(DW'(i));
    m_ready = 1'b1;
    enable  = 1'b1;
    base = hs_total;
    first_valid = 0;
    start_cyc = 0;
    for (int n = 1; n <= 12 && first_valid == 0; n++) begin
      @(negedge rd_clk);
      if (m_valid) begin
        first_valid = n;
        start_cyc = cyc;
      end
    end
    check("fill_latency", 64'(first_valid), 64'd4);
    for (int n = 0; n < 300 && hs_total - base < 100; n++) @(negedge rd_clk);
    check("tput_count", 64'(hs_total - base), 64'd100);
    check("tput_no_gaps", 64'(last_hs_cyc - start_cyc), 64'd99);
    @(negedge rd_clk);
    check("tput_end_valid", 64'(m_valid), 64'd0);

    // Backpressure for 20 cycles mid-stream.
    for (int i = 100; i < 140; i++) push_word(DW'(i));
    base = hs_total;
    for (int n = 0; n < 50 && hs_total - base < 5; n++) @(negedge rd_clk);
    m_ready = 1'b0;
    max_occ = 0;
`ifdef FIFO_RD_STATS_EN
    stall_base = int'(stall_cycles);
`endif
    repeat (20) @(negedge rd_clk);
    check("bp_rd_en_low", 64'(fifo_rd_en), 64'd0);
    check("bp_valid_high", 64'(m_valid), 64'd1);
    check("bp_max_held", 64'(max_occ), 64'(BDEPTH));
`ifdef FIFO_RD_STATS_EN
    check("bp_stall_cycles", 64'(int'(stall_cycles) - stall_base), 64'd20);
`endif
    m_ready = 1'b1;
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge rd_clk);
    check("bp_all_delivered", 64'(exp_q.size()), 64'd0);
    @(negedge rd_clk);
`ifdef FIFO_RD_STATS_EN
    check("words_out", 64'(words_out), 64'(hs_total));
`endif

    // Single word into an empty FIFO.
    rd_base = rd_total;
    base = hs_total;
    push_word(36'h9_ABCD_1234);
    repeat (10) @(negedge rd_clk);
    check("single_rd_pulses", 64'(rd_total - rd_base), 64'd1);
    check("single_handshakes", 64'(hs_total - base), 64'd1);
    check("single_valid_low", 64'(m_valid), 64'd0);

    // Drain: enable drops with 2 in flight and 1 buffered.
    m_ready = 1'b0;
    rd_base = rd_total;
    base = hs_total;
    for (int i = 0; i < 5; i++) push_word(DW'(200 + i));
    repeat (3) @(negedge rd_clk);
    enable = 1'b0;
    repeat (3) @(negedge rd_clk);
    check("drain_holding", 64'(m_valid), 64'd1);
    check("drain_not_idle", 64'(idle), 64'd0);
    m_ready = 1'b1;
    for (int n = 0; n < 20 && !idle; n++) @(negedge rd_clk);
    check("drain_idle", 64'(idle), 64'd1);
    check("drain_rd_pulses", 64'(rd_total - rd_base), 64'd3);
    check("drain_handshakes", 64'(hs_total - base), 64'd3);

    // Reset mid-stream with three words buffered.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(DW'(300 + i));
    enable = 1'b1;
    repeat (6) @(negedge rd_clk);
    check("pre_rst_valid", 64'(m_valid), 64'd1);
    rst_n = 1'b0;
    fq.delete();
    exp_q.delete();
    #1;
    check("midrst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("midrst_valid", 64'(m_valid), 64'd0);
    check("midrst_data", 64'(m_data), 64'd0);
    check("midrst_idle", 64'(idle), 64'd1);
    @(negedge rd_clk);
    enable = 1'b0;
    m_ready = 1'b1;
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge rd_clk);
      check("postrst_valid_low", 64'(m_valid), 64'd0);
    end
    base = hs_total;
    push_word(36'h0_5A5A_5A5A);
    enable = 1'b1;
    for (int n = 0; n < 20 && hs_total - base < 1; n++) @(negedge rd_clk);
    check("postrst_word", 64'(hs_total - base), 64'd1);
`ifdef FIFO_RD_STATS_EN
    @(negedge rd_clk);
    check("postrst_words_out", 64'(words_out), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
